// File: rtl/data_memory_banked.sv
// Big-endian byte/half/word data memory: post-reset init sweep, one outstanding request, configurable load latency.
// Optional DMEM_PARITY_EN stores an even-parity bit per byte and flags parity errors on loads.
module data_memory_banked #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 64,
    parameter int                ADDR_W      = 32,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE  = DATA_W'(32'h0000_0001)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    localparam int               IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0]  CAP       = (ADDR_W+1)'(DEPTH_WORDS * 4);
    localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [3:0]       WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

    function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        logic bad;
        case (sz)
            2'd0:    bad = 1'b0;
            2'd1:    bad = a[0];
            2'd2:    bad = (a[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || ({1'b0, a} >= CAP);
    endfunction

    // Bit 3 is the byte at offset 0 (bits 31:24).
    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'd0:    be = 4'b1000 >> off;
            2'd1:    be = off[1] ? 4'b0011 : 4'b1100;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [1:0]          ld_size_q, ld_size_d;
    logic                ld_signed_q, ld_signed_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                init_done_q, init_done_d;

    logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];
`ifdef DMEM_PARITY_EN
    logic [3:0]          par_q [DEPTH_WORDS];
`endif

    logic [3:0]          mem_we;
    logic [IDX_W-1:0]    mem_widx;
    logic [DATA_W-1:0]   mem_wdata;

    logic                accept, req_err, st_ok;
    logic [DATA_W-1:0]   st_data;
    logic [ADDR_W-1:0]   sel_addr;
    logic [1:0]          sel_size, sel_off;
    logic                sel_signed, ld_err;
    logic [IDX_W-1:0]    sel_idx;
    logic [DATA_W-1:0]   rd_word, ld_data;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign init_done  = init_done_q;

    assign accept  = req_valid && req_ready;
    assign req_err = addr_err(req_addr, req_size);
    assign st_ok   = accept && req_write && !req_err;

    always_comb begin
        case (req_size)
            2'd0:    st_data = {4{req_wdata[7:0]}};
            2'd1:    st_data = {2{req_wdata[15:0]}};
            default: st_data = req_wdata;
        endcase
    end

    // With zero wait the load is answered straight from IDLE, so read the live request there.
    always_comb begin
        sel_addr   = (state_q == S_IDLE) ? req_addr   : ld_addr_q;
        sel_size   = (state_q == S_IDLE) ? req_size   : ld_size_q;
        sel_signed = (state_q == S_IDLE) ? req_signed : ld_signed_q;
        sel_off    = sel_addr[1:0];
        sel_idx    = sel_addr[IDX_W+1:2];
        rd_word    = mem_q[sel_idx];
        case (sel_off)
            2'd0:    ld_byte = rd_word[31:24];
            2'd1:    ld_byte = rd_word[23:16];
            2'd2:    ld_byte = rd_word[15:8];
            default: ld_byte = rd_word[7:0];
        endcase
        ld_half = sel_off[1] ? rd_word[15:0] : rd_word[31:16];
        case (sel_size)
            2'd0:    ld_data = sel_signed ? {{(DATA_W-8){ld_byte[7]}}, ld_byte}
                                          : {{(DATA_W-8){1'b0}}, ld_byte};
            2'd1:    ld_data = sel_signed ? {{(DATA_W-16){ld_half[15]}}, ld_half}
                                          : {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data = rd_word;
        endcase
        ld_err = addr_err(sel_addr, sel_size);
`ifdef DMEM_PARITY_EN
        for (int k = 0; k < 4; k++) begin
            if (lane_be(sel_size, sel_off)[k] && (par_q[sel_idx][k] != ^rd_word[8*k +: 8]))
                ld_err = 1'b1;
        end
`endif
    end

    always_comb begin
        mem_we    = 4'b0000;
        mem_widx  = init_cnt_q;
        mem_wdata = INIT_VALUE;
        if (state_q == S_INIT && !reset) begin
            mem_we = 4'b1111;
        end else if (st_ok) begin
            mem_we    = lane_be(req_size, req_addr[1:0]);
            mem_widx  = req_addr[IDX_W+1:2];
            mem_wdata = st_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
                mem_q[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
`ifdef DMEM_PARITY_EN
                par_q[mem_widx][k] <= ^mem_wdata[8*k +: 8];
`endif
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        ld_addr_d    = ld_addr_q;
        ld_size_d    = ld_size_q;
        ld_signed_d  = ld_signed_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        init_done_d  = init_done_q;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d  = '0;
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (accept && req_write) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = req_err;
                    resp_rdata_d = '0;
                end else if (accept) begin
                    ld_addr_d   = req_addr;
                    ld_size_d   = req_size;
                    ld_signed_d = req_signed;
                    wait_cnt_d  = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ld_err;
                        resp_rdata_d = ld_err ? '0 : ld_data;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ld_err;
                    resp_rdata_d = ld_err ? '0 : ld_data;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            init_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            ld_addr_q    <= '0;
            ld_size_q    <= '0;
            ld_signed_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            ld_addr_q    <= ld_addr_d;
            ld_size_q    <= ld_size_d;
            ld_signed_q  <= ld_signed_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            init_done_q  <= init_done_d;
        end
    end

endmodule
